// File: rtl/sram_controller_pwr_fsm.sv
// rtl/sram_controller_pwr_fsm.sv - SRAM power-save sequencer: drain, isolate, sleep, wake, de-isolate.
// Optional drain timeout is enabled by defining SRAM_PWR_TIMEOUT_EN.
module sram_controller_pwr_fsm #(
    parameter int ISO_CYCLES    = 4,
    parameter int WAKE_CYCLES   = 8,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic       clk_ctrl,
    input  logic       reset,
    input  logic       pwr_save_req_sync,
    input  logic       pwr_restore_req_sync,
    input  logic       ctrl_idle,
    output logic       access_block,
    output logic       sram_iso,
    output logic       sram_sleep,
    output logic       pwr_save_ack,
    output logic       pwr_restore_ack,
    output logic       pwr_err,
    output logic [2:0] pwr_state
);

`ifdef SRAM_PWR_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [7:0] ISO_LAST   = 8'(ISO_CYCLES - 1);
    localparam logic [7:0] WAKE_LAST  = 8'(WAKE_CYCLES - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_ACTIVE = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ISO    = 3'd2,
        ST_SLEEP  = 3'd3,
        ST_WAKE   = 3'd4,
        ST_DEISO  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_d;
    logic       access_block_q, sram_iso_q, sram_sleep_q;
    logic       save_ack_q, restore_ack_q, err_q;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_ACTIVE: if (pwr_save_req_sync && !pwr_restore_req_sync) state_d = ST_DRAIN;
            ST_DRAIN: begin
                // Dropping the save request wins over a simultaneous idle.
                if (!pwr_save_req_sync) begin
                    state_d = ST_ACTIVE;
                end else if (ctrl_idle) begin
                    state_d = ST_ISO;
                end else if (TIMEOUT_EN && cnt_q == DRAIN_LAST) begin
                    state_d = ST_ACTIVE;
                    err_d   = 1'b1;
                end
            end
            ST_ISO:    if (cnt_q == ISO_LAST) state_d = ST_SLEEP;
            ST_SLEEP:  if (pwr_restore_req_sync) state_d = ST_WAKE;
            ST_WAKE:   if (cnt_q == WAKE_LAST) state_d = ST_DEISO;
            ST_DEISO:  state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase

        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == 8'hFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_ctrl) begin
        if (reset) begin
            state_q        <= ST_ACTIVE;
            cnt_q          <= 8'd0;
            access_block_q <= 1'b0;
            sram_iso_q     <= 1'b0;
            sram_sleep_q   <= 1'b0;
            save_ack_q     <= 1'b0;
            restore_ack_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            access_block_q <= (state_d != ST_ACTIVE);
            sram_iso_q     <= (state_d == ST_ISO) || (state_d == ST_SLEEP) || (state_d == ST_WAKE);
            sram_sleep_q   <= (state_d == ST_SLEEP);
            save_ack_q     <= (state_d == ST_SLEEP);
            restore_ack_q  <= (state_q == ST_DEISO);
            err_q          <= err_d;
        end
    end

    assign access_block    = access_block_q;
    assign sram_iso        = sram_iso_q;
    assign sram_sleep      = sram_sleep_q;
    assign pwr_save_ack    = save_ack_q;
    assign pwr_restore_ack = restore_ack_q;
    assign pwr_err         = err_q;
    assign pwr_state       = state_q;

endmodule

// File: tb/tb_sram_controller_pwr_fsm.sv
// tb/tb_sram_controller_pwr_fsm.sv - self-checking bench for sram_controller_pwr_fsm.
module tb_sram_controller_pwr_fsm;

    localparam int ISO  = 4;
    localparam int WAKE = 8;
    localparam int DTO  = 16;

`ifdef SRAM_PWR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk_ctrl = 1'b0;
    logic       reset = 1'b1;
    logic       save = 1'b0, restore = 1'b0, idle = 1'b1;
    logic       access_block, sram_iso, sram_sleep, pwr_save_ack, pwr_restore_ack, pwr_err;
    logic [2:0] pwr_state;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: phase number plus cycles already spent in it.
    int m_st  = 0;
    int m_age = 0;
    bit m_rack = 0, m_err = 0;

    always #5 clk_ctrl = ~clk_ctrl;

    sram_controller_pwr_fsm #(
        .ISO_CYCLES(ISO), .WAKE_CYCLES(WAKE), .DRAIN_TIMEOUT(DTO)
    ) dut (
        .clk_ctrl(clk_ctrl), .reset(reset),
        .pwr_save_req_sync(save), .pwr_restore_req_sync(restore), .ctrl_idle(idle),
        .access_block(access_block), .sram_iso(sram_iso), .sram_sleep(sram_sleep),
        .pwr_save_ack(pwr_save_ack), .pwr_restore_ack(pwr_restore_ack),
        .pwr_err(pwr_err), .pwr_state(pwr_state)
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit s, input bit r, input bit i, input bit rst);
        int nxt;
        nxt    = m_st;
        m_rack = 0;
        m_err  = 0;
        if (rst) begin
            m_st  = 0;
            m_age = 0;
            return;
        end
        case (m_st)
            0: if (s && !r) nxt = 1;
            1: begin
                if (!s) nxt = 0;
                else if (i) nxt = 2;
                else if (TO_EN && m_age + 1 >= DTO) begin
                    nxt   = 0;
                    m_err = 1;
                end
            end
            2: if (m_age + 1 >= ISO) nxt = 3;
            3: if (r) nxt = 4;
            4: if (m_age + 1 >= WAKE) nxt = 5;
            default: begin
                nxt    = 0;
                m_rack = 1;
            end
        endcase
        m_age = (nxt == m_st) ? m_age + 1 : 0;
        m_st  = nxt;
    endtask

    function automatic logic [8:0] model_vec();
        logic [8:0] v;
        v[8:6] = 3'(m_st);
        v[5]   = (m_st != 0);
        v[4]   = (m_st >= 2 && m_st <= 4);
        v[3]   = (m_st == 3);
        v[2]   = (m_st == 3);
        v[1]   = m_rack;
        v[0]   = m_err;
        return v;
    endfunction

    function automatic logic [8:0] dut_vec();
        return {pwr_state, access_block, sram_iso, sram_sleep, pwr_save_ack, pwr_restore_ack, pwr_err};
    endfunction

    task automatic cyc(input bit s, input bit r, input bit i, input bit rst);
        save = s; restore = r; idle = i; reset = rst;
        @(posedge clk_ctrl);
        model_step(s, r, i, rst);
        #1;
        check("cycle", dut_vec(), model_vec());
    endtask

    initial begin
        int n;
        bit s, r, i, rst;

        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        check("reset_outputs", dut_vec(), 9'd0);

        n = 0;
        do begin cyc(1, 0, 1, 0); n++; end while (!pwr_save_ack && n < 40);
        check("save_latency", 9'(n), 9'(ISO + 2));

        n = 0;
        do begin cyc(1, 1, 1, 0); n++; end while (!pwr_restore_ack && n < 40);
        check("restore_latency", 9'(n), 9'(WAKE + 2));

        for (int k = 0; k < 10; k++) begin
            cyc(1, 1, 1, 0);
            check("both_hold_state", 9'(pwr_state), 9'd0);
        end

        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("abort_to_active", 9'(pwr_state), 9'd0);

        for (int k = 0; k < ISO + 3; k++) cyc(1, 0, 1, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 1);
        check("reset_mid_wake", dut_vec(), 9'd0);
        cyc(0, 0, 1, 0);

        for (int k = 0; k < DTO + 3; k++) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);

        s = 0; r = 0; i = 1; rst = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15) == 0) s = ~s;
            if ($urandom_range(7) == 0) r = ~r;
            i   = ($urandom_range(3) != 0);
            rst = ($urandom_range(199) == 0);
            cyc(s, r, i, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
